mdbrot_iter: RTL
================

# mdbrot_iter

Mandelbrot escape-time iteration engine. It consumes one complex point c in sign-magnitude fixed point, iterates z ← z² + c from z = 0, and reports the iteration count at escape or at the cap. Three existing qmult instances compute the squares and the cross term, and this block adds the sequencing and accumulation around them. It sits between the pixel coordinate generator (upstream, supplies c) and the colour mapper (downstream, consumes iter/escaped).

## Interface
- Q, 15, fractional bits of all fixed-point values
- N, 32, total word width; bit N-1 is sign, bits N-2:0 are magnitude
- MAX_ITER, 255, iteration cap; must satisfy MAX_ITER < 2^ITER_W
- ITER_W, 8, width of the iteration count
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- c_re  in  N  real part of c; sign-magnitude Q(N-1-Q).Q
- c_im  in  N  imaginary part of c; same format
- busy  out  1  high from the edge accepting start until the edge done rises
- done  out  1  one-cycle pulse; iter and escaped are valid in the same cycle
- iter  out  ITER_W  final iteration index n
- escaped  out  1  1 means |z_n|² > 4.0; 0 means the cap was reached

## Operation
- States: IDLE, MULT, EVAL, DONE.
- IDLE: if start=1, latch c, set zr=zi=0 and k=0, set busy=1, then go to MULT. Otherwise hold.
- MULT: register zr², zi² and zr·zi, taken from the combinational qmult outputs. Then go to EVAL.
- EVAL, escape test: if mag(zr²)+mag(zi²) > ESC_LIMIT (4<<Q), set escaped=1 and iter=k, then go to DONE.
  - The sum is computed unsigned on N bits. Squares are always non-negative.
- EVAL, cap: else if k == MAX_ITER, set escaped=0 and iter=MAX_ITER, then go to DONE.
- EVAL, update: otherwise
  - zr ← zr² − zi² + c_re
  - zi ← 2·(zr·zi) + c_im
  - k ← k+1
  - return to MULT.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. iter and escaped hold until the next done.
- Arithmetic:
  - Negation flips the sign bit only.
  - Doubling shifts the magnitude left by 1; the MSB of the magnitude is dropped.
  - Magnitude overflow in addition is truncated. No saturation and no flag.
- Zero handling: −0 (sign=1, magnitude=0) compares equal to +0. All adder results with zero magnitude are emitted as +0.
- start outside IDLE is ignored. c is held internally, so the c inputs may change after acceptance.
- Asynchronous reset at any time:
  - returns the block to IDLE
  - clears busy, done, iter, escaped, z and k
  - any in-flight point is lost.

## Timing
- Each iteration costs 2 cycles (MULT + EVAL).
- Latency: done is high in the cycle after edge 2·(n+1), counting the accepting edge as edge 0.
  - n=0 gives done after 2 edges.
  - The cap gives done after 2·(MAX_ITER+1) edges.
- Throughput: the next start is accepted in the cycle after done, which is the IDLE cycle.
- Reset values: busy=0, done=0, iter=0, escaped=0.

## Configuration
- MDBROT_ITER_ABORT_EN defined:
  - adds input abort (1 bit)
  - abort=1 in MULT or EVAL forces IDLE on the next edge: busy=0, no done pulse, iter/escaped unchanged
  - abort has priority over the EVAL exit decisions
  - abort in IDLE or DONE has no effect.
- Not defined: the port is absent and every point runs to escape or the cap.

## Structure
- Shared package mdbrot_pkg holds:
  - the state encoding (IDLE/MULT/EVAL/DONE)
  - default Q and N
  - ESC_LIMIT = 4<<Q
  - the sign-magnitude zero constant.
- Sub-module qadd: combinational sign-magnitude adder, parameterised by N.
  - Inputs a, b; output sum.
  - Same-sign inputs add magnitudes. Differing signs subtract the smaller magnitude from the larger, and the sign follows the larger.
  - Zero result is emitted as +0.
  - Three instances: zr² + (−zi²), that result + c_re, and 2·zrzi + c_im.
- qmult is instantiated three times, unmodified.

## Test plan
- c=(3.0,0) (c_re=0x0001_8000) → escaped=1, iter=1; done after 4 edges.
- c=(2.0,0) (0x0001_0000) → escaped=1, iter=2; the case |z|²=4 exactly must not escape.
- c=(1.0,0) → escaped=1, iter=3.
- c=(−2.0,0) (0x8001_0000) and c=(0,1.0) (c_im=0x0000_8000) → escaped=0, iter=255; done after 512 edges.
- start pulsed while busy; rst_n dropped mid-iteration → second start ignored; after reset all outputs are 0, and a fresh start on c=(3.0,0) gives iter=1.
- With MDBROT_ITER_ABORT_EN: abort during iteration 10 of c=0 → busy falls next edge, no done pulse, previous iter retained.

Source files
------------

// File: rtl/mdbrot_pkg.sv
// Shared definitions for the Mandelbrot escape-time engine: state encoding,
// default fixed-point geometry, escape threshold and the sign-magnitude zero.
package mdbrot_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } mdbrot_state_e;

  localparam int DEF_Q = 15;
  localparam int DEF_N = 32;

  localparam logic [DEF_N-1:0] ESC_LIMIT = DEF_N'(4) << DEF_Q;
  localparam logic [DEF_N-1:0] SM_ZERO   = '0;

endpackage

// File: rtl/mdbrot_iter_if.sv
// Point request / result bundle between the coordinate generator (master)
// and the iteration engine (slave).
interface mdbrot_iter_if #(
  parameter int N      = 32,
  parameter int ITER_W = 8
);
  // start is a request sampled only while the engine is idle; busy covers
  // the whole computation and done pulses once with iter/escaped valid.
  logic              start;
  logic [N-1:0]      c_re;
  logic [N-1:0]      c_im;
  logic              busy;
  logic              done;
  logic [ITER_W-1:0] iter;
  logic              escaped;

  modport master (output start, c_re, c_im, input busy, done, iter, escaped);
  modport slave  (input start, c_re, c_im, output busy, done, iter, escaped);
endinterface

// File: rtl/qadd.sv
// Combinational sign-magnitude adder; magnitude overflow wraps and a zero
// result is always emitted as +0.
module qadd
  import mdbrot_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  logic [N-2:0] mag;
  logic         sgn;

  always_comb begin
    mag = '0;
    sgn = 1'b0;
    if (a[N-1] == b[N-1]) begin
      mag = a[N-2:0] + b[N-2:0];
      sgn = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      mag = a[N-2:0] - b[N-2:0];
      sgn = a[N-1];
    end else begin
      mag = b[N-2:0] - a[N-2:0];
      sgn = b[N-1];
    end
    sum = (mag == '0) ? N'(SM_ZERO) : {sgn, mag};
  end
endmodule

// File: rtl/qmult.sv
// Combinational sign-magnitude fixed-point multiplier (magnitude truncated
// to Q fractional bits, high product bits dropped).
module qmult #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result
);
  logic [2*N-3:0] prod;
  logic           unused_prod_bits;

  assign prod     = i_multiplicand[N-2:0] * i_multiplier[N-2:0];
  assign o_result = {i_multiplicand[N-1] ^ i_multiplier[N-1], prod[N-2+Q:Q]};
  assign unused_prod_bits = ^{prod[2*N-3:N-1+Q], prod[Q-1:0]};
endmodule

// File: rtl/mdbrot_iter.sv
// Mandelbrot escape-time engine: iterates z <- z^2 + c from z = 0, two cycles
// per iteration. Optional abort input enabled by MDBROT_ITER_ABORT_EN.
module mdbrot_iter
  import mdbrot_pkg::*;
#(
  parameter int Q        = DEF_Q,
  parameter int N        = DEF_N,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef MDBROT_ITER_ABORT_EN
  input  logic          abort,
`endif
  mdbrot_iter_if.slave  bus,
  output mdbrot_state_e dbg_state_o
);
  mdbrot_state_e     state_q;
  logic [N-1:0]      c_re_q, c_im_q, zr_q, zi_q;
  logic [N-1:0]      zr2_q, zi2_q, zrzi_q;
  logic [ITER_W-1:0] k_q, iter_q;
  logic              busy_q, done_q, escaped_q;

  logic [N-1:0] zr2_c, zi2_c, zrzi_c;
  logic [N-1:0] diff_c, zrzi_x2, zr_d, zi_d, mag_sum;
  logic         esc_c, abort_w, unused_zrzi_msb;

`ifdef MDBROT_ITER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  qmult #(.Q(Q), .N(N)) u_mul_rr (.i_multiplicand(zr_q), .i_multiplier(zr_q), .o_result(zr2_c));
  qmult #(.Q(Q), .N(N)) u_mul_ii (.i_multiplicand(zi_q), .i_multiplier(zi_q), .o_result(zi2_c));
  qmult #(.Q(Q), .N(N)) u_mul_ri (.i_multiplicand(zr_q), .i_multiplier(zi_q), .o_result(zrzi_c));

  // Real part: zr^2 + (-zi^2) + c_re; negation is a sign flip.
  qadd #(.N(N)) u_add_diff (.a(zr2_q), .b({~zi2_q[N-1], zi2_q[N-2:0]}), .sum(diff_c));
  qadd #(.N(N)) u_add_re   (.a(diff_c), .b(c_re_q), .sum(zr_d));

  // Doubling drops the magnitude MSB.
  assign zrzi_x2         = {zrzi_q[N-1], zrzi_q[N-3:0], 1'b0};
  assign unused_zrzi_msb = zrzi_q[N-2];
  qadd #(.N(N)) u_add_im (.a(zrzi_x2), .b(c_im_q), .sum(zi_d));

  assign mag_sum = {1'b0, zr2_q[N-2:0]} + {1'b0, zi2_q[N-2:0]};
  assign esc_c   = mag_sum > N'(ESC_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      c_re_q    <= '0;
      c_im_q    <= '0;
      zr_q      <= '0;
      zi_q      <= '0;
      zr2_q     <= '0;
      zi2_q     <= '0;
      zrzi_q    <= '0;
      k_q       <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      escaped_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            c_re_q  <= bus.c_re;
            c_im_q  <= bus.c_im;
            zr_q    <= '0;
            zi_q    <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MULT;
          end
        end
        S_MULT: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            zr2_q   <= zr2_c;
            zi2_q   <= zi2_c;
            zrzi_q  <= zrzi_c;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (abort_w) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (esc_c) begin
            escaped_q <= 1'b1;
            iter_q    <= k_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else if (k_q == ITER_W'(MAX_ITER)) begin
            escaped_q <= 1'b0;
            iter_q    <= ITER_W'(MAX_ITER);
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            k_q     <= k_q + 1'b1;
            state_q <= S_MULT;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.iter    = iter_q;
  assign bus.escaped = escaped_q;
  assign dbg_state_o = state_q;
endmodule
